// File: rtl/ifmap_multicast_ctrl.sv
// Per-PE multicast snooper: captures bus words tagged for this PE (row/col or
// all-ones wildcard) into a one-entry stage and pushes them into the ifmap FIFO.
module ifmap_multicast_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     configure,
  input  logic [ROW_TAG_WIDTH-1:0] row_id_in,
  input  logic [COL_TAG_WIDTH-1:0] col_id_in,
  input  logic                     bus_valid,
  input  logic [ROW_TAG_WIDTH-1:0] bus_row_tag,
  input  logic [COL_TAG_WIDTH-1:0] bus_col_tag,
  input  logic [DATA_WIDTH-1:0]    bus_data,
  input  logic                     bus_accept,
  output logic                     bus_ready,
  output logic [DATA_WIDTH-1:0]    ifmap,
  output logic                     push_ifmap,
  input  logic                     ifmap_fifo_full,
  output logic [CNT_WIDTH-1:0]     delivered_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [ROW_TAG_WIDTH-1:0] row_id_q, row_id_d;
  logic [COL_TAG_WIDTH-1:0] col_id_q, col_id_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic row_hit_s, col_hit_s, match_s, out_valid_s, push_s, slot_free_s, capture_s;

  // Tag match, handshake and output-stage control
  always_comb begin
    row_hit_s   = (bus_row_tag == row_id_q) || (bus_row_tag == {ROW_TAG_WIDTH{1'b1}});
    col_hit_s   = (bus_col_tag == col_id_q) || (bus_col_tag == {COL_TAG_WIDTH{1'b1}});
    match_s     = bus_valid & row_hit_s & col_hit_s;
    out_valid_s = (state_q == ST_FULL);
    push_s      = out_valid_s & ~ifmap_fifo_full;
    slot_free_s = ~out_valid_s | push_s;
    // slot_free_s is redundant for a legal bus_accept; it keeps a protocol
    // violation from overwriting a stalled word.
    capture_s   = bus_accept & match_s & ~configure & slot_free_s;

    bus_ready  = ~configure & (~match_s | slot_free_s);
    push_ifmap = push_s;
    ifmap      = out_data_q;

    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (capture_s) state_d = ST_FULL;
        else           state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (capture_s)   state_d = ST_FULL;
        else if (push_s) state_d = ST_EMPTY;
        else             state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (capture_s) out_data_d = bus_data;
    else           out_data_d = out_data_q;

    if (configure) begin
      row_id_d = row_id_in;
      col_id_d = col_id_in;
    end else begin
      row_id_d = row_id_q;
      col_id_d = col_id_q;
    end

    // configure wins over a same-cycle increment
    if (configure)   cnt_d = {CNT_WIDTH{1'b0}};
    else if (push_s) cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    else             cnt_d = cnt_q;
  end

  assign delivered_count = cnt_q;

  // State and data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      row_id_q   <= {ROW_TAG_WIDTH{1'b0}};
      col_id_q   <= {COL_TAG_WIDTH{1'b0}};
      out_data_q <= {DATA_WIDTH{1'b0}};
      cnt_q      <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      row_id_q   <= row_id_d;
      col_id_q   <= col_id_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ifmap_multicast_ctrl.sv
// Bench for ifmap_multicast_ctrl: directed vector table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_ifmap_multicast_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        configure = 1'b0;
  logic [3:0]  row_id_in = 4'd0;
  logic [4:0]  col_id_in = 5'd0;
  logic        bus_valid = 1'b0;
  logic [3:0]  bus_row_tag = 4'd0;
  logic [4:0]  bus_col_tag = 5'd0;
  logic [15:0] bus_data = 16'd0;
  logic        bus_accept = 1'b0;
  logic        bus_ready;
  logic [15:0] ifmap;
  logic        push_ifmap;
  logic        ifmap_fifo_full = 1'b0;
  logic [15:0] delivered_count;

  int n_tests = 0;
  int n_fail  = 0;

  ifmap_multicast_ctrl dut (
    .clk(clk), .reset(reset), .configure(configure),
    .row_id_in(row_id_in), .col_id_in(col_id_in),
    .bus_valid(bus_valid), .bus_row_tag(bus_row_tag), .bus_col_tag(bus_col_tag),
    .bus_data(bus_data), .bus_accept(bus_accept), .bus_ready(bus_ready),
    .ifmap(ifmap), .push_ifmap(push_ifmap), .ifmap_fifo_full(ifmap_fifo_full),
    .delivered_count(delivered_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cfg;
    logic [3:0]  rin;
    logic [4:0]  cin;
    logic        v;
    logic [3:0]  rt;
    logic [4:0]  ct;
    logic [15:0] d;
    logic        acc;
    logic        full;
    logic        e_rdy;
    logic        e_push;
    logic [15:0] e_if;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic cfg, input logic [3:0] rin, input logic [4:0] cin,
                              input logic v, input logic [3:0] rt, input logic [4:0] ct,
                              input logic [15:0] d, input logic acc, input logic full,
                              input logic e_rdy, input logic e_push, input logic [15:0] e_if,
                              input logic [15:0] e_cnt);
    vec_t r;
    r.cfg = cfg; r.rin = rin; r.cin = cin; r.v = v; r.rt = rt; r.ct = ct; r.d = d;
    r.acc = acc; r.full = full; r.e_rdy = e_rdy; r.e_push = e_push; r.e_if = e_if; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cfg, input logic [3:0] rin, input logic [4:0] cin,
                       input logic v, input logic [3:0] rt, input logic [4:0] ct,
                       input logic [15:0] d, input logic acc, input logic full);
    configure = cfg; row_id_in = rin; col_id_in = cin;
    bus_valid = v; bus_row_tag = rt; bus_col_tag = ct; bus_data = d;
    bus_accept = acc; ifmap_fifo_full = full;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #3;
    reset = 1'b1;
    tick();
  endtask

  // Reference model state
  logic [15:0] held_q[$];
  logic [15:0] m_last;
  logic [3:0]  m_row;
  logic [4:0]  m_col;
  logic [15:0] m_cnt;

  initial begin
    // Directed table: expectations are sampled before the edge of that row.
    tbl[0]  = mk(1, 4'd2, 5'd3, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  0, 0, 16'h0000, 16'd0);
    tbl[1]  = mk(0, 4'd0, 5'd0, 1, 4'd2, 5'd3,  16'h00A5, 1, 0,  1, 0, 16'h0000, 16'd0);
    tbl[2]  = mk(0, 4'd0, 5'd0, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  1, 1, 16'h00A5, 16'd0);
    tbl[3]  = mk(0, 4'd0, 5'd0, 1, 4'd1, 5'd3,  16'h1111, 1, 0,  1, 0, 16'h00A5, 16'd1);
    tbl[4]  = mk(0, 4'd0, 5'd0, 1, 4'd2, 5'h1F, 16'h0B0B, 1, 0,  1, 0, 16'h00A5, 16'd1);
    tbl[5]  = mk(0, 4'd0, 5'd0, 0, 4'd0, 5'd0,  16'h0000, 0, 1,  1, 0, 16'h0B0B, 16'd1);
    tbl[6]  = mk(0, 4'd0, 5'd0, 1, 4'd2, 5'd3,  16'h0C0C, 0, 1,  0, 0, 16'h0B0B, 16'd1);
    tbl[7]  = mk(0, 4'd0, 5'd0, 1, 4'd2, 5'd3,  16'h0C0C, 1, 0,  1, 1, 16'h0B0B, 16'd1);
    tbl[8]  = mk(0, 4'd0, 5'd0, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  1, 1, 16'h0C0C, 16'd2);
    tbl[9]  = mk(0, 4'd0, 5'd0, 1, 4'd2, 5'd3,  16'h0D0D, 1, 0,  1, 0, 16'h0C0C, 16'd3);
    tbl[10] = mk(1, 4'd5, 5'd7, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  0, 1, 16'h0D0D, 16'd3);
    tbl[11] = mk(0, 4'd0, 5'd0, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  1, 0, 16'h0D0D, 16'd0);
    tbl[12] = mk(1, 4'd5, 5'd7, 1, 4'd5, 5'd7,  16'h0E0E, 1, 0,  0, 0, 16'h0D0D, 16'd0);
    tbl[13] = mk(0, 4'd0, 5'd0, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  1, 0, 16'h0D0D, 16'd0);
    tbl[14] = mk(0, 4'd0, 5'd0, 1, 4'd5, 5'd7,  16'h1234, 1, 0,  1, 0, 16'h0D0D, 16'd0);
    tbl[15] = mk(0, 4'd0, 5'd0, 1, 4'd5, 5'd7,  16'h5678, 1, 1,  0, 0, 16'h1234, 16'd0);
    tbl[16] = mk(0, 4'd0, 5'd0, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  1, 1, 16'h1234, 16'd0);
    tbl[17] = mk(0, 4'd0, 5'd0, 0, 4'd0, 5'd0,  16'h0000, 0, 0,  1, 0, 16'h1234, 16'd1);

    // Reset state
    #2;
    chk("reset_push", {31'd0, push_ifmap}, 32'd0);
    chk("reset_ifmap", {16'd0, ifmap}, 32'd0);
    chk("reset_cnt", {16'd0, delivered_count}, 32'd0);
    chk("reset_ready", {31'd0, bus_ready}, 32'd1);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].cfg, tbl[i].rin, tbl[i].cin, tbl[i].v, tbl[i].rt, tbl[i].ct,
            tbl[i].d, tbl[i].acc, tbl[i].full);
      #2;
      chk($sformatf("tbl%0d_ready", i), {31'd0, bus_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_push", i), {31'd0, push_ifmap}, {31'd0, tbl[i].e_push});
      chk($sformatf("tbl%0d_ifmap", i), {16'd0, ifmap}, {16'd0, tbl[i].e_if});
      chk($sformatf("tbl%0d_cnt", i), {16'd0, delivered_count}, {16'd0, tbl[i].e_cnt});
      tick();
    end

    // Stream 8 matching words back to back (IDs are 5/7)
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b0, 4'd0, 5'd0, 1'b1, 4'd5, 5'd7, 16'h4000 + 16'(i), 1'b1, 1'b0);
      else       idle();
      #2;
      if (i < 8) chk($sformatf("stream%0d_ready", i), {31'd0, bus_ready}, 32'd1);
      if (i > 0) begin
        chk($sformatf("stream%0d_push", i), {31'd0, push_ifmap}, 32'd1);
        chk($sformatf("stream%0d_data", i), {16'd0, ifmap}, 32'h4000 + 32'(i - 1));
      end
      tick();
    end
    chk("stream_cnt", {16'd0, delivered_count}, 32'd9);

    // Reset while a word is stalled behind a full FIFO
    drive(1'b0, 4'd0, 5'd0, 1'b1, 4'd5, 5'd7, 16'h7777, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b0, 4'd0, 5'd0, 16'h0000, 1'b0, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_push", {31'd0, push_ifmap}, 32'd0);
    chk("rst_mid_cnt", {16'd0, delivered_count}, 32'd0);
    chk("rst_mid_ifmap", {16'd0, ifmap}, 32'd0);
    #1;
    reset = 1'b1;
    tick();
    drive(1'b0, 4'd0, 5'd0, 1'b1, 4'd0, 5'd0, 16'h0F0F, 1'b1, 1'b0);
    #2;
    chk("rst_id00_ready", {31'd0, bus_ready}, 32'd1);
    tick();
    idle();
    #2;
    chk("rst_id00_push", {31'd0, push_ifmap}, 32'd1);
    chk("rst_id00_data", {16'd0, ifmap}, 32'h0F0F);
    tick();

    // Counter wrap: 65535 pushes then one more
    drive(1'b1, 4'd1, 5'd1, 1'b0, 4'd0, 5'd0, 16'h0000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b0, 4'd0, 5'd0, 1'b1, 4'd1, 5'd1, 16'(i), 1'b1, 1'b0);
      tick();
    end
    idle();
    tick();
    #2;
    chk("wrap_max", {16'd0, delivered_count}, 32'hFFFF);
    drive(1'b0, 4'd0, 5'd0, 1'b1, 4'd1, 5'd1, 16'hABCD, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    #2;
    chk("wrap_zero", {16'd0, delivered_count}, 32'd0);

    // Randomized run against the reference model
    do_reset();
    held_q.delete();
    m_last = 16'd0; m_row = 4'd0; m_col = 5'd0; m_cnt = 16'd0;
    for (int c = 0; c < 3000; c++) begin
      logic cfg, v, full, acc, m_match, m_push, m_rdy;
      logic [3:0] rin, rt;
      logic [4:0] cin, ct;
      logic [15:0] d;
      int sel;
      cfg  = ($urandom_range(15) == 0);
      rin  = 4'($urandom_range(3));
      cin  = 5'($urandom_range(3));
      v    = ($urandom_range(3) != 0);
      full = ($urandom_range(2) == 0);
      d    = 16'($urandom);
      sel  = $urandom_range(3);
      rt   = (sel == 0) ? 4'hF : ((sel == 3) ? 4'($urandom) : m_row);
      sel  = $urandom_range(3);
      ct   = (sel == 0) ? 5'h1F : ((sel == 3) ? 5'($urandom) : m_col);
      m_match = v && (rt == m_row || rt == 4'hF) && (ct == m_col || ct == 5'h1F);
      m_push  = (held_q.size() != 0) && !full;
      m_rdy   = !cfg && (!m_match || held_q.size() == 0 || m_push);
      acc = v && m_rdy && ($urandom_range(3) != 0);
      if ($urandom_range(31) == 0) acc = v;
      drive(cfg, rin, cin, v, rt, ct, d, acc, full);
      #2;
      chk("rnd_ready", {31'd0, bus_ready}, {31'd0, m_rdy});
      chk("rnd_push", {31'd0, push_ifmap}, {31'd0, m_push});
      chk("rnd_ifmap", {16'd0, ifmap}, {16'd0, m_last});
      chk("rnd_cnt", {16'd0, delivered_count}, {16'd0, m_cnt});
      tick();
      if (m_push) void'(held_q.pop_front());
      if (acc && m_match && !cfg && held_q.size() == 0) begin
        held_q.push_back(d);
        m_last = d;
      end
      if (cfg) begin
        m_cnt = 16'd0; m_row = rin; m_col = cin;
      end else if (m_push) begin
        m_cnt = m_cnt + 16'd1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
